// File: rtl/sram_arbiter.sv
// ---------------------------------------------------------------------------
// sram_arbiter
//
// Shares one asynchronous 1Mx16 SRAM port between the CPU memory interface
// and the program loader/debug port. A round-robin arbiter picks a requester
// in IDLE. Each transfer then runs WAIT_CYCLES cycles of ACCESS followed by
// one DONE cycle. DONE holds the strobes inactive (except CE/UB/LB) and
// pulses the winner's ready. The parent module drives the inout Data bus
// from sram_dout while sram_doe is high, and feeds the sampled bus back on
// sram_din.
//
// Parameters
//   WAIT_CYCLES  SRAM access cycles per transfer (legal range 1..15)
//   ADDR_W       SRAM address width
//   DATA_W       SRAM data width
//
// Ports
//   Clk, Reset                       rising-edge clock, async active-high reset
//   cpu_req/we/addr/wdata            CPU request; req is held until cpu_ready
//   cpu_rdata, cpu_ready             CPU read data, one-cycle completion pulse
//   ldr_req/we/addr/wdata            loader request, same rules as the CPU
//   ldr_rdata, ldr_ready             loader read data, completion pulse
//   busy                             high whenever the FSM is not in IDLE
//   ADDR, CE, UB, LB, OE, WE         SRAM address and active-low strobes
//   sram_dout, sram_doe, sram_din    write data, bus drive enable, bus sample
//   state_dbg                        current FSM state (IDLE=0, ACCESS=1, DONE=2)
//
// Handshake: a requester raises req together with we/addr/wdata and holds req
// until it sees its ready pulse. It must drop req in the cycle after ready,
// or it is arbitrated again as a new access. The command fields are latched
// at grant, so later changes to them are ignored. Requests are only looked
// at in IDLE.
//
// Optional feature (macro LOADER_LOCK_EN): adds input ldr_lock. While
// ldr_lock is high in IDLE, only the loader can be granted.
// ---------------------------------------------------------------------------
module sram_arbiter #(
    parameter int WAIT_CYCLES = 2,
    parameter int ADDR_W      = 20,
    parameter int DATA_W      = 16
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ready,
    input  logic              ldr_req,
    input  logic              ldr_we,
    input  logic [ADDR_W-1:0] ldr_addr,
    input  logic [DATA_W-1:0] ldr_wdata,
    output logic [DATA_W-1:0] ldr_rdata,
    output logic              ldr_ready,
`ifdef LOADER_LOCK_EN
    input  logic              ldr_lock,
`endif
    output logic              busy,
    output logic [ADDR_W-1:0] ADDR,
    output logic              CE,
    output logic              UB,
    output logic              LB,
    output logic              OE,
    output logic              WE,
    output logic [DATA_W-1:0] sram_dout,
    output logic              sram_doe,
    input  logic [DATA_W-1:0] sram_din,
    output logic [1:0]        state_dbg
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic GNT_CPU = 1'b0;
    localparam logic GNT_LDR = 1'b1;

    // Four bits are enough for the full 1..15 wait-state range.
    localparam int              CNT_W    = 4;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

    state_t              state, state_nxt;
    logic                grant, grant_nxt;
    logic                last_grant, last_grant_nxt;
    logic [CNT_W-1:0]    cnt, cnt_nxt;
    logic                lat_we, lat_we_nxt;
    logic [ADDR_W-1:0]   addr_nxt;
    logic [DATA_W-1:0]   dout_nxt;
    logic [DATA_W-1:0]   cpu_rdata_nxt, ldr_rdata_nxt;
    logic                cpu_elig, ldr_elig, pick;

    logic                ce_nxt, oe_nxt, we_nxt, doe_nxt;
    logic                cpu_ready_nxt, ldr_ready_nxt, busy_nxt;

    assign state_dbg = state;

    // Arbitration, sequencing and datapath next-state.
    always_comb begin
        state_nxt      = state;
        grant_nxt      = grant;
        last_grant_nxt = last_grant;
        cnt_nxt        = cnt;
        lat_we_nxt     = lat_we;
        addr_nxt       = ADDR;
        dout_nxt       = sram_dout;
        cpu_rdata_nxt  = cpu_rdata;
        ldr_rdata_nxt  = ldr_rdata;
        cpu_elig       = cpu_req;
        ldr_elig       = ldr_req;
        pick           = GNT_CPU;
`ifdef LOADER_LOCK_EN
        if (ldr_lock) begin
            cpu_elig = 1'b0;
        end
`endif
        case (state)
            IDLE: begin
                if (cpu_elig || ldr_elig) begin
                    // A tie goes to whoever was not served last.
                    if (cpu_elig && ldr_elig) begin
                        pick = (last_grant == GNT_LDR) ? GNT_CPU : GNT_LDR;
                    end else begin
                        pick = ldr_elig ? GNT_LDR : GNT_CPU;
                    end
                    grant_nxt      = pick;
                    last_grant_nxt = pick;
                    cnt_nxt        = CNT_LOAD;
                    lat_we_nxt     = (pick == GNT_LDR) ? ldr_we    : cpu_we;
                    addr_nxt       = (pick == GNT_LDR) ? ldr_addr  : cpu_addr;
                    dout_nxt       = (pick == GNT_LDR) ? ldr_wdata : cpu_wdata;
                    state_nxt      = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt == '0) begin
                    state_nxt = DONE;
                    // Read data is sampled at the end of the last OE-low cycle.
                    if (!lat_we) begin
                        if (grant == GNT_CPU) begin
                            cpu_rdata_nxt = sram_din;
                        end else begin
                            ldr_rdata_nxt = sram_din;
                        end
                    end
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Strobes are decoded from the next state and then registered. This way
    // the pins change cleanly on the clock edge that enters each state.
    always_comb begin
        ce_nxt        = 1'b1;
        oe_nxt        = 1'b1;
        we_nxt        = 1'b1;
        doe_nxt       = 1'b0;
        cpu_ready_nxt = 1'b0;
        ldr_ready_nxt = 1'b0;
        busy_nxt      = (state_nxt != IDLE);
        case (state_nxt)
            ACCESS: begin
                ce_nxt  = 1'b0;
                oe_nxt  = lat_we_nxt;
                we_nxt  = ~lat_we_nxt;
                doe_nxt = lat_we_nxt;
            end
            DONE: begin
                ce_nxt        = 1'b0;
                // Keep driving write data one extra cycle for SRAM hold time.
                doe_nxt       = lat_we_nxt;
                cpu_ready_nxt = (grant_nxt == GNT_CPU);
                ldr_ready_nxt = (grant_nxt == GNT_LDR);
            end
            default: begin
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Datapath and registered outputs.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            grant      <= GNT_CPU;
            last_grant <= GNT_LDR;   // the CPU wins the first tie
            cnt        <= '0;
            lat_we     <= 1'b0;
            ADDR       <= '0;
            sram_dout  <= '0;
            cpu_rdata  <= '0;
            ldr_rdata  <= '0;
            cpu_ready  <= 1'b0;
            ldr_ready  <= 1'b0;
            busy       <= 1'b0;
            CE         <= 1'b1;
            UB         <= 1'b1;
            LB         <= 1'b1;
            OE         <= 1'b1;
            WE         <= 1'b1;
            sram_doe   <= 1'b0;
        end else begin
            grant      <= grant_nxt;
            last_grant <= last_grant_nxt;
            cnt        <= cnt_nxt;
            lat_we     <= lat_we_nxt;
            ADDR       <= addr_nxt;
            sram_dout  <= dout_nxt;
            cpu_rdata  <= cpu_rdata_nxt;
            ldr_rdata  <= ldr_rdata_nxt;
            cpu_ready  <= cpu_ready_nxt;
            ldr_ready  <= ldr_ready_nxt;
            busy       <= busy_nxt;
            CE         <= ce_nxt;
            UB         <= ce_nxt;
            LB         <= ce_nxt;
            OE         <= oe_nxt;
            WE         <= we_nxt;
            sram_doe   <= doe_nxt;
        end
    end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Shares the single 1Mx16 asynchronous SRAM port between two requesters: the CPU memory interface (MAR/MDR path) and the program loader/debug port.
- Arbitrates round-robin and sequences each access through an FSM that drives the active-low CE/UB/LB/OE/WE strobes with a parameterised wait-state count.
- Controls the data-bus output enable. The parent drives the inout Data bus from sram_dout/sram_doe and samples sram_din.

Parameters:
WAIT_CYCLES, 2, SRAM access cycles per transfer; legal range 1..15; 0 is illegal
ADDR_W, 20, address width
DATA_W, 16, data width

Ports:
Clk  input  1  system clock, rising edge
Reset  input  1  asynchronous, active-high reset
cpu_req  input  1  CPU access request; held high until cpu_ready
cpu_we  input  1  1 = write, 0 = read
cpu_addr  input  ADDR_W  CPU address
cpu_wdata  input  DATA_W  CPU write data
cpu_rdata  output  DATA_W  read data returned to CPU
cpu_ready  output  1  one-cycle completion pulse to CPU
ldr_req, ldr_we, ldr_addr, ldr_wdata  input  1/1/ADDR_W/DATA_W  loader request signals, same rules as CPU
ldr_rdata  output  DATA_W  read data returned to loader
ldr_ready  output  1  one-cycle completion pulse to loader
busy  output  1  high whenever state is not IDLE
ADDR  output  ADDR_W  SRAM address
CE, UB, LB, OE, WE  output  1  SRAM strobes, active low
sram_dout  output  DATA_W  write data for the bus
sram_doe  output  1  parent drives Data from sram_dout when high
sram_din  input  DATA_W  Data bus as sampled

Behaviour:
- States: IDLE, ACCESS, DONE. Registered signals: grant (CPU/LDR), wait counter, latched addr/we/wdata, last_grant, rdata registers.
- Reset values: state=IDLE, all strobes=1, sram_doe=0, ADDR=0, sram_dout=0, both rdata=0, both ready=0, busy=0, last_grant=LDR (so the CPU wins the first tie).
- IDLE, only one request: grant that requester.
- IDLE, both requests: grant the requester that is not last_grant.
- IDLE, on grant: latch addr/we/wdata, load counter with WAIT_CYCLES-1, go to ACCESS, update last_grant.
- ACCESS lasts exactly WAIT_CYCLES cycles:
  - CE=UB=LB=0 throughout.
  - Read: OE=0, WE=1, sram_doe=0.
  - Write: WE=0, OE=1, sram_doe=1.
  - Counter decrements each cycle. When the counter is 0, the read data (sram_din) is registered into the granted rdata and the FSM goes to DONE.
- DONE lasts 1 cycle:
  - CE=UB=LB=0, OE=WE=1.
  - sram_doe stays 1 for writes (hold time).
  - Granted ready=1; the other ready stays 0. Next state is IDLE.
- Latency: request sampled in IDLE at cycle n -> ready high in cycle n+WAIT_CYCLES+1. Back-to-back throughput is one access per WAIT_CYCLES+2 cycles.
- Request rules:
  - Requests are ignored in ACCESS and DONE.
  - A requester must drop req in the cycle after ready, otherwise it is re-arbitrated as a new access.
  - A change to addr/we/wdata after grant has no effect, because the values are latched.
- rdata holds its value until the next read for that requester; a write does not alter rdata.
- ADDR holds the latched address in ACCESS/DONE and the last value in IDLE.
- Strobes and sram_doe are registered outputs (glitch-free).
- Reset mid-access: all strobes return to 1 and sram_doe to 0 asynchronously. The transfer is abandoned with no ready pulse.

Optional Feature:
LOADER_LOCK_EN
- Defined: adds input ldr_lock (1 bit). While ldr_lock=1 in IDLE, only ldr_req is eligible for grant and CPU requests wait. Round-robin resumes when ldr_lock=0. ldr_lock is ignored outside IDLE.
- Undefined: the port is absent and arbitration is pure round-robin.

Test Plan:
- CPU read, WAIT_CYCLES=2: cpu_req=1, cpu_we=0, addr=0x00010, sram_din=0xBEEF -> CE/OE low cycles 1-3 (OE low only in 1-2), cpu_ready pulse in cycle 3, cpu_rdata=0xBEEF.
- Loader write: addr=0x0FFFF, wdata=0x1234 -> WE low exactly 2 cycles, sram_doe high 3 cycles, ADDR=0x0FFFF, sram_dout=0x1234, ldr_ready single pulse.
- Both requests held continuously -> grants alternate CPU, LDR, CPU, LDR; each ready pulse separated by 4 cycles.
- Reset asserted during the 2nd ACCESS cycle of a write -> WE/CE go high in the same cycle, sram_doe=0, no ready pulse; a new cpu_req after reset completes normally.
- WAIT_CYCLES=1 build: read -> ready in cycle n+2; WAIT_CYCLES=15 build: read -> ready in cycle n+16.
- With LOADER_LOCK_EN and ldr_lock=1, both requesting -> 3 consecutive loader grants, cpu_ready stays 0; drop the lock -> the CPU is granted next.
